lbm_chunk_scheduler: RTL and testbench

//  Sequences chunked transfers between the AXIS pixel writer and the LBM solver.
//  - Opens a fill window on the writer by driving its address limit, and counts the beats it accepts.
//  - Closes the window after DEPTH pixels and hands the chunk to the solver.
//  - Repeats for num_chunks chunks, flagging AXIS framing errors.

---
 rtl/lbm_chunk_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_lbm_chunk_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbm_chunk_scheduler.sv
// Chunked fill/compute sequencer between the AXIS pixel writer and the LBM solver.
// Optional fill watchdog enabled by defining LBM_SCHED_TIMEOUT_EN.
module lbm_chunk_scheduler #(
    parameter int DEPTH          = 2500,
    parameter int ADDRESS_WIDTH  = 12,
    parameter int CHUNK_W        = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic                     start,
    input  logic [CHUNK_W-1:0]       num_chunks,
    input  logic                     beat,
    input  logic                     beat_last,
    input  logic                     chunk_transfer_ready,
    output logic [ADDRESS_WIDTH-1:0] fill_limit,
    output logic                     chunk_compute_ready,
    output logic [CHUNK_W-1:0]       chunk_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     len_err,
    output logic                     timeout_err
);

    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LIMIT = ADDRESS_WIDTH'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_CNT    = ADDRESS_WIDTH'(DEPTH - 1);

    generate
        if (DEPTH < 1 || DEPTH >= (2 ** ADDRESS_WIDTH) || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("lbm_chunk_scheduler: DEPTH must fit in ADDRESS_WIDTH and TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] fill_cnt_reg, fill_cnt_next;
    logic [ADDRESS_WIDTH-1:0] fill_limit_reg, fill_limit_next;
    logic                     compute_ready_reg, compute_ready_next;
    logic [CHUNK_W-1:0]       chunk_idx_reg, chunk_idx_next;
    logic [CHUNK_W-1:0]       num_chunks_reg, num_chunks_next;
    logic                     len_err_reg, len_err_next;
    logic                     watchdog_fire;
    logic                     start_accepted;
    logic                     fill_at_last;

    assign start_accepted = (state_reg == ST_IDLE) && start;
    assign fill_at_last   = (fill_cnt_reg == LAST_CNT);

`ifdef LBM_SCHED_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt_reg;
    logic              timeout_err_reg;

    // Beat takes priority over the watchdog: a pixel arriving on the last allowed cycle still counts.
    assign watchdog_fire = (state_reg == ST_FILL) && !beat &&
                           (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            idle_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg != ST_FILL || beat) begin
                idle_cnt_reg <= '0;
            end else if (!watchdog_fire) begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end
            if (start_accepted) begin
                timeout_err_reg <= 1'b0;
            end else if (watchdog_fire) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign watchdog_fire = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_reg         <= ST_IDLE;
            fill_cnt_reg      <= '0;
            fill_limit_reg    <= '0;
            compute_ready_reg <= 1'b0;
            chunk_idx_reg     <= '0;
            num_chunks_reg    <= '0;
            len_err_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            fill_cnt_reg      <= fill_cnt_next;
            fill_limit_reg    <= fill_limit_next;
            compute_ready_reg <= compute_ready_next;
            chunk_idx_reg     <= chunk_idx_next;
            num_chunks_reg    <= num_chunks_next;
            len_err_reg       <= len_err_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        fill_cnt_next      = fill_cnt_reg;
        fill_limit_next    = fill_limit_reg;
        compute_ready_next = compute_ready_reg;
        chunk_idx_next     = chunk_idx_reg;
        num_chunks_next    = num_chunks_reg;
        len_err_next       = len_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    len_err_next   = 1'b0;
                    chunk_idx_next = '0;
                    fill_cnt_next  = '0;
                    if (num_chunks != '0) begin
                        num_chunks_next = num_chunks;
                        fill_limit_next = DEPTH_LIMIT;
                        state_next      = ST_FILL;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_FILL: begin
                if (beat) begin
                    if (fill_at_last || beat_last) begin
                        // tlast must coincide exactly with the final pixel of the chunk.
                        if (beat_last != fill_at_last) begin
                            len_err_next = 1'b1;
                        end
                        fill_limit_next    = '0;
                        compute_ready_next = 1'b1;
                        fill_cnt_next      = '0;
                        state_next         = ST_COMPUTE;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + ADDRESS_WIDTH'(1);
                    end
                end else if (watchdog_fire) begin
                    fill_limit_next = '0;
                    state_next      = ST_IDLE;
                end
            end

            ST_COMPUTE: begin
                if (chunk_transfer_ready) begin
                    compute_ready_next = 1'b0;
                    if (chunk_idx_reg == num_chunks_reg - CHUNK_W'(1)) begin
                        state_next = ST_DONE;
                    end else begin
                        chunk_idx_next  = chunk_idx_reg + CHUNK_W'(1);
                        fill_cnt_next   = '0;
                        fill_limit_next = DEPTH_LIMIT;
                        state_next      = ST_FILL;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Stray beats are flagged last so they win over the clear of an accepted start.
        if (beat && state_reg != ST_FILL) begin
            len_err_next = 1'b1;
        end
    end

    assign fill_limit          = fill_limit_reg;
    assign chunk_compute_ready = compute_ready_reg;
    assign chunk_idx           = chunk_idx_reg;
    assign busy                = (state_reg == ST_FILL) || (state_reg == ST_COMPUTE);
    assign done                = (state_reg == ST_DONE);
    assign len_err             = len_err_reg;

endmodule

// File: tb/tb_lbm_chunk_scheduler.sv
// Bench for lbm_chunk_scheduler: vector table, directed corner sequences, randomized runs vs scoreboard.
module tb_lbm_chunk_scheduler;

    localparam int DEPTH = 8;
    localparam int AW    = 12;
    localparam int CW    = 16;
    localparam int TO    = 16;

    logic          clk = 1'b0;
    logic          srst;
    logic          start;
    logic [CW-1:0] num_chunks;
    logic          beat;
    logic          beat_last;
    logic          xfer;
    logic [AW-1:0] fill_limit;
    logic          compute_ready;
    logic [CW-1:0] chunk_idx;
    logic          busy;
    logic          done;
    logic          len_err;
    logic          timeout_err;

    always #5 clk = ~clk;

    lbm_chunk_scheduler #(
        .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .CHUNK_W(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_areset(srst),
        .start(start),
        .num_chunks(num_chunks),
        .beat(beat),
        .beat_last(beat_last),
        .chunk_transfer_ready(xfer),
        .fill_limit(fill_limit),
        .chunk_compute_ready(compute_ready),
        .chunk_idx(chunk_idx),
        .busy(busy),
        .done(done),
        .len_err(len_err),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    typedef struct {
        logic          st;
        logic [CW-1:0] n;
        logic          b;
        logic          bl;
        logic          x;
        logic [AW-1:0] fl;
        logic          cr;
        logic [CW-1:0] idx;
        logic          bsy;
        logic          dn;
        logic          le;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, int n, logic b, logic bl, logic x,
                                int fl, logic cr, int idx, logic bsy, logic dn, logic le);
        vec_t v;
        v.st = st; v.n = CW'(n); v.b = b; v.bl = bl; v.x = x;
        v.fl = AW'(fl); v.cr = cr; v.idx = CW'(idx); v.bsy = bsy; v.dn = dn; v.le = le;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
        else $display("ok   %s = %0d", name, act);
    endtask

    // Inputs are applied 1 time unit after an edge; outputs are read 1 unit after the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0; beat = 1'b0; beat_last = 1'b0; xfer = 1'b0;
    endtask

    task automatic beats(input int k, input bit last_on_final);
        for (int i = 1; i <= k; i++) begin
            beat = 1'b1;
            beat_last = (i == k) && last_on_final;
            step();
        end
    endtask

    task automatic begin_run(input int n);
        start = 1'b1; num_chunks = CW'(n);
        step();
        num_chunks = '0;
    endtask

    // Randomized run: expectations come from the run plan, not from cycle tracking.
    task automatic random_run(input int r);
        int  n, len, gap, d0;
        bit  miss, stray, exp_err;
        n = $urandom_range(1, 4);
        exp_err = 0;
        d0 = done_seen;
        begin_run(n);
        for (int c = 0; c < n; c++) begin
            len  = ($urandom % 3 == 0) ? $urandom_range(1, DEPTH - 1) : DEPTH;
            miss = (len == DEPTH) && ($urandom % 4 == 0);
            if (len < DEPTH || miss) exp_err = 1;
            check($sformatf("rnd%0d.c%0d.idx", r, c), 32'(chunk_idx), 32'(c));
            for (int k = 1; k <= len; k++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                if (gap != 0)
                    check($sformatf("rnd%0d.c%0d.open", r, c), {19'd0, fill_limit, compute_ready},
                          {19'd0, AW'(DEPTH), 1'b0});
                beat = 1'b1;
                beat_last = (k == len) && !miss;
                step();
            end
            check($sformatf("rnd%0d.c%0d.closed", r, c), {19'd0, fill_limit, compute_ready},
                  {19'd0, AW'(0), 1'b1});
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            stray = ($urandom % 5 == 0);
            if (stray) exp_err = 1;
            xfer = 1'b1; beat = stray;
            step();
            if (c < n - 1)
                check($sformatf("rnd%0d.c%0d.reopen", r, c), {19'd0, fill_limit, compute_ready},
                      {19'd0, AW'(DEPTH), 1'b0});
            else
                check($sformatf("rnd%0d.done", r), {30'd0, done, busy}, 32'b10);
        end
        step();
        check($sformatf("rnd%0d.len_err", r), 32'(len_err), 32'(exp_err));
        check($sformatf("rnd%0d.done_count", r), 32'(done_seen - d0), 32'd1);
    endtask

    initial begin
        int d0;
        srst = 1'b1; start = 1'b0; num_chunks = '0; beat = 1'b0; beat_last = 1'b0; xfer = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", {fill_limit, compute_ready, chunk_idx, busy, done, len_err},
              {AW'(0), 1'b0, CW'(0), 1'b0, 1'b0, 1'b0});
        check("reset.timeout_err", 32'(timeout_err), 32'd0);
        srst = 1'b0;

        // Single full chunk.
        tbl.push_back(mk(1, 1, 0, 0, 0, 8, 0, 0, 1, 0, 0));
        for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 8, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Two chunks, first ends early on beat 5.
        tbl.push_back(mk(1, 2, 0, 0, 0, 8, 0, 0, 1, 0, 0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 8, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8, 0, 1, 1, 0, 1));
        for (int k = 0; k < 7; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 8, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        // Zero-chunk run: done next cycle, writer never opened, error cleared.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            start = tbl[i].st; num_chunks = tbl[i].n; beat = tbl[i].b;
            beat_last = tbl[i].bl; xfer = tbl[i].x;
            step();
            check($sformatf("vec%0d", i), {fill_limit, compute_ready, chunk_idx, busy, done, len_err},
                  {tbl[i].fl, tbl[i].cr, tbl[i].idx, tbl[i].bsy, tbl[i].dn, tbl[i].le});
        end

        // Three chunks with ignored start/transfer_ready in FILL and a stray beat on transfer_ready.
        d0 = done_seen;
        begin_run(3);
        beats(2, 0);
        start = 1'b1; num_chunks = CW'(1);
        step();
        num_chunks = '0;
        check("seq3.start_ignored", {fill_limit, chunk_idx, busy}, {AW'(DEPTH), CW'(0), 1'b1});
        xfer = 1'b1;
        step();
        check("seq3.xfer_ignored", {fill_limit, compute_ready}, {AW'(DEPTH), 1'b0});
        beats(6, 1);
        check("seq3.c0_closed", {fill_limit, compute_ready, len_err}, {AW'(0), 1'b1, 1'b0});
        xfer = 1'b1;
        step();
        check("seq3.c1_open", {fill_limit, compute_ready, chunk_idx}, {AW'(DEPTH), 1'b0, CW'(1)});
        beats(8, 1);
        xfer = 1'b1; beat = 1'b1;
        step();
        check("seq3.c2_open", {fill_limit, chunk_idx, len_err}, {AW'(DEPTH), CW'(2), 1'b1});
        beats(7, 0);
        check("seq3.stray_not_counted", 32'(compute_ready), 32'd0);
        beats(1, 1);
        check("seq3.c2_closed", {compute_ready, chunk_idx}, {1'b1, CW'(2)});
        step();
        check("seq3.no_early_done", 32'(done_seen - d0), 32'd0);
        xfer = 1'b1;
        step();
        check("seq3.done", {done, busy}, 2'b10);
        step();
        check("seq3.done_count", 32'(done_seen - d0), 32'd1);

        // Reset in the middle of a fill, then a clean refill from zero.
        begin_run(1);
        beats(4, 0);
        srst = 1'b1;
        step();
        check("rst_mid.outputs", {fill_limit, compute_ready, chunk_idx, busy, done, len_err},
              {AW'(0), 1'b0, CW'(0), 1'b0, 1'b0, 1'b0});
        srst = 1'b0;
        begin_run(1);
        beats(7, 0);
        check("rst_mid.not_yet_full", 32'(compute_ready), 32'd0);
        beats(1, 1);
        check("rst_mid.full", {compute_ready, len_err}, 2'b10);
        xfer = 1'b1;
        step();
        step();

`ifdef LBM_SCHED_TIMEOUT_EN
        d0 = done_seen;
        begin_run(1);
        repeat (15) step();
        check("tmo.before", 32'(timeout_err), 32'd0);
        step();
        check("tmo.fire", {timeout_err, fill_limit, busy, compute_ready}, {1'b1, AW'(0), 1'b0, 1'b0});
        step();
        check("tmo.no_done", 32'(done_seen - d0), 32'd0);
        begin_run(1);
        check("tmo.cleared", 32'(timeout_err), 32'd0);
        beats(8, 1);
        xfer = 1'b1;
        step();
        step();
`else
        begin_run(1);
        repeat (40) step();
        check("notmo.waits", {timeout_err, fill_limit, busy}, {1'b0, AW'(DEPTH), 1'b1});
        beats(8, 1);
        xfer = 1'b1;
        step();
        step();
`endif

        for (int r = 0; r < 30; r++) random_run(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
